// File: rtl/instr_mem_param.sv
// Loadable IF-stage instruction memory with self-clearing sweep and fault detection; optional parity via IM_PARITY_EN.
// Latency: fetch result registered 1 cycle after addr; clear sweep holds busy for DEPTH cycles after reset.
// Backpressure: stall freezes the fetch outputs; loads are accepted every RUN cycle and dropped while busy.
module instr_mem_param #(
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 256,
    parameter int                ADDR_W   = 32,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              EnIM,
    input  logic              stall,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              fault,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
`ifdef IM_PARITY_EN
    input  logic              ld_par_inv,
`endif
    output logic              busy,
    output logic              par_err
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        RUN   = 2'd1
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic                vld_q, vld_d;
    logic                fault_q, fault_d;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic                mem_we;
    logic [IDX_W-1:0]    mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

    logic [IDX_W-1:0]    idx, ld_idx;
    logic                addr_ok, ld_ok;
    logic [DATA_W-1:0]   rd_word;

    assign idx     = addr[IDX_W+1:2];
    assign ld_idx  = ld_addr[IDX_W+1:2];
    assign addr_ok = (addr[1:0] == 2'b00) && ((addr >> 2) < ADDR_W'(DEPTH));
    assign ld_ok   = (ld_addr[1:0] == 2'b00) && ((ld_addr >> 2) < ADDR_W'(DEPTH));
    assign rd_word = mem[idx];

`ifdef IM_PARITY_EN
    logic                par_mem [DEPTH];
    logic                mem_wpar;
    logic                rd_par_err;
    logic                par_err_q, par_err_d;

    assign rd_par_err = par_mem[idx] != (^rd_word);
    assign mem_wpar   = (state_q == CLEAR) ? (^NOP_WORD) : ((^ld_data) ^ ld_par_inv);
    assign par_err    = par_err_q;
`else
    assign par_err    = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        instr_d   = instr_q;
        vld_d     = vld_q;
        fault_d   = fault_q;
        mem_we    = 1'b0;
        mem_waddr = ld_idx;
        mem_wdata = ld_data;
`ifdef IM_PARITY_EN
        par_err_d = par_err_q;
`endif
        case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = cnt_q;
                mem_wdata = NOP_WORD;
                cnt_d     = cnt_q + 1'b1;
                instr_d   = '0;
                vld_d     = 1'b0;
                fault_d   = 1'b0;
`ifdef IM_PARITY_EN
                par_err_d = 1'b0;
`endif
                if (cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                mem_we = ld_en && ld_ok;
                // Memory write lands at the edge, so a same-word fetch sees the old word.
                if (!stall) begin
                    if (!EnIM) begin
                        instr_d = '0;
                        vld_d   = 1'b0;
                        fault_d = 1'b0;
                    end else if (!addr_ok) begin
                        instr_d = NOP_WORD;
                        vld_d   = 1'b0;
                        fault_d = 1'b1;
                    end else begin
                        instr_d = rd_word;
                        vld_d   = 1'b1;
                        fault_d = 1'b0;
                    end
`ifdef IM_PARITY_EN
                    par_err_d = EnIM && addr_ok && rd_par_err;
`endif
                end
            end
            default: begin
                state_d = CLEAR;
                cnt_d   = '0;
                instr_d = '0;
                vld_d   = 1'b0;
                fault_d = 1'b0;
`ifdef IM_PARITY_EN
                par_err_d = 1'b0;
`endif
            end
        endcase
        if (rst) begin
            mem_we = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            cnt_q     <= '0;
            instr_q   <= '0;
            vld_q     <= 1'b0;
            fault_q   <= 1'b0;
`ifdef IM_PARITY_EN
            par_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            instr_q   <= instr_d;
            vld_q     <= vld_d;
            fault_q   <= fault_d;
`ifdef IM_PARITY_EN
            par_err_q <= par_err_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
`ifdef IM_PARITY_EN
            par_mem[mem_waddr] <= mem_wpar;
`endif
        end
    end

    assign instr       = instr_q;
    assign instr_valid = vld_q;
    assign fault       = fault_q;
    assign busy        = (state_q != RUN);

endmodule

// File: tb/tb_instr_mem_param.sv
// Bench for instr_mem_param: directed scenarios followed by random traffic, all checked against a word-array model.
module tb_instr_mem_param;

    localparam int          DEPTH = 256;
    localparam logic [31:0] NOP   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst, EnIM, stall, ld_en, ld_par_inv;
    logic [31:0] addr, ld_addr, ld_data, instr;
    logic        instr_valid, fault, busy, par_err;

    instr_mem_param #(
        .DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .NOP_WORD(NOP)
    ) dut (
        .clk(clk), .rst(rst), .EnIM(EnIM), .stall(stall), .addr(addr),
        .instr(instr), .instr_valid(instr_valid), .fault(fault),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
`ifdef IM_PARITY_EN
        .ld_par_inv(ld_par_inv),
`endif
        .busy(busy), .par_err(par_err)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: plain word array plus "words left to clear" count.
    logic [31:0] ref_mem [DEPTH];
    bit          ref_bad [DEPTH];
    int          clear_left = 0;
    logic [31:0] e_instr = '0;
    bit          e_vld = 0, e_fault = 0, e_par = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [31:0] a);
        return (a[1:0] == 2'b00) && ((a >> 2) < 32'(DEPTH));
    endfunction

    task automatic step();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ref_mem[i] = NOP;
                ref_bad[i] = 0;
            end
            clear_left = DEPTH;
            e_instr = '0; e_vld = 0; e_fault = 0; e_par = 0;
        end else if (clear_left > 0) begin
            clear_left--;
            e_instr = '0; e_vld = 0; e_fault = 0; e_par = 0;
        end else begin
            if (!stall) begin
                if (!EnIM) begin
                    e_instr = '0; e_vld = 0; e_fault = 0; e_par = 0;
                end else if (!legal(addr)) begin
                    e_instr = NOP; e_vld = 0; e_fault = 1; e_par = 0;
                end else begin
                    e_instr = ref_mem[addr >> 2];
                    e_vld = 1; e_fault = 0;
                    e_par = ref_bad[addr >> 2];
                end
            end
            if (ld_en && legal(ld_addr)) begin
                ref_mem[ld_addr >> 2] = ld_data;
                ref_bad[ld_addr >> 2] = ld_par_inv;
            end
        end
        #1;
        chk("instr", instr, e_instr);
        chk("instr_valid", 32'(instr_valid), 32'(e_vld));
        chk("fault", 32'(fault), 32'(e_fault));
        chk("busy", 32'(busy), 32'(clear_left > 0));
        chk("par_err", 32'(par_err), 32'(e_par));
    endtask

    task automatic fetch(input logic [31:0] a);
        addr = a; EnIM = 1'b1;
        step();
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d, input logic inv);
        ld_en = 1'b1; ld_addr = a; ld_data = d; ld_par_inv = inv;
        step();
        ld_en = 1'b0; ld_par_inv = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] w;
        logic [31:0] k;
        w = $urandom_range(0, 15);
        k = $urandom_range(0, 9);
        if (k < 8)  return w << 2;
        if (k == 8) return (w << 2) | 32'($urandom_range(1, 3));
        if ($urandom_range(0, 1) == 0) return (w + 32'(DEPTH) * 32'($urandom_range(1, 3))) << 2;
        return (w << 2) | 32'h8000_0000;
    endfunction

    initial begin
        rst = 1'b1; EnIM = 1'b0; stall = 1'b0; ld_en = 1'b0; ld_par_inv = 1'b0;
        addr = '0; ld_addr = '0; ld_data = '0;

        // Clear sweep: busy for exactly DEPTH cycles, then NOP words everywhere.
        step();
        rst = 1'b0;
        chk("busy_after_rst", 32'(busy), 32'd1);
        repeat (DEPTH) step();
        chk("busy_done", 32'(busy), 32'd0);
        fetch(32'h3FC);
        chk("cleared_word", instr, 32'h0);
        chk("cleared_vld", 32'(instr_valid), 32'd1);

        // Load then fetch.
        load(32'h0, 32'h0121_0003, 1'b0);
        load(32'h4, 32'h1314_0000, 1'b0);
        load(32'h10, 32'hF978_0000, 1'b0);
        fetch(32'h0);  chk("ld_fetch0", instr, 32'h0121_0003);
        fetch(32'h4);  chk("ld_fetch4", instr, 32'h1314_0000);
        fetch(32'h10); chk("ld_fetch16", instr, 32'hF978_0000);
        chk("ld_fetch16_flt", 32'(fault), 32'd0);

        // Faults and an out-of-range load that must not alias onto word 0.
        fetch(32'h6);
        chk("misalign_fault", 32'(fault), 32'd1);
        chk("misalign_instr", instr, NOP);
        fetch(32'h400);
        chk("range_fault", 32'(fault), 32'd1);
        EnIM = 1'b0;
        load(32'h400, 32'h1234_5678, 1'b0);
        fetch(32'h0);
        chk("no_alias", instr, 32'h0121_0003);

        // Stall hold with a moving address, then release.
        fetch(32'h4);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            addr = 32'h10 + 32'(i) * 4;
            step();
            chk("stall_hold", instr, 32'h1314_0000);
        end
        stall = 1'b0;
        addr = 32'h10;
        step();
        chk("stall_release", instr, 32'hF978_0000);
        EnIM = 1'b0;
        step();
        chk("disable_instr", instr, 32'h0);
        chk("disable_vld", 32'(instr_valid), 32'd0);

        // Read-before-write on the same word.
        addr = 32'h8; EnIM = 1'b1;
        load(32'h8, 32'hAAAA_5555, 1'b0);
        chk("rbw_old", instr, 32'h0);
        fetch(32'h8);
        chk("rbw_new", instr, 32'hAAAA_5555);

        // Reset mid-run wipes loaded contents.
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (DEPTH) step();
        fetch(32'h8);
        chk("rst_wipe", instr, 32'h0);

`ifdef IM_PARITY_EN
        EnIM = 1'b0;
        load(32'hC, 32'h0000_000F, 1'b1);
        fetch(32'hC);
        chk("par_inj", 32'(par_err), 32'd1);
        chk("par_inj_vld", 32'(instr_valid), 32'd1);
        EnIM = 1'b0;
        load(32'hC, 32'h0000_000F, 1'b0);
        fetch(32'hC);
        chk("par_clean", 32'(par_err), 32'd0);
`endif

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            rst     = ($urandom_range(0, 999) == 0);
            stall   = ($urandom_range(0, 3) == 0);
            EnIM    = ($urandom_range(0, 4) != 0);
            addr    = rand_addr();
            ld_en   = ($urandom_range(0, 2) == 0);
            ld_addr = rand_addr();
            ld_data = $urandom;
`ifdef IM_PARITY_EN
            ld_par_inv = ($urandom_range(0, 3) == 0);
`else
            ld_par_inv = 1'b0;
`endif
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
